// File: rtl/intersection_pkg.sv
// Shared state encoding and direction constants for the intersection sequencer.
package intersection_pkg;

   typedef enum logic [8:0] {
      OFF       = 9'b0_0000_0001,
      STARTUP   = 9'b0_0000_0010,
      NS_GREEN  = 9'b0_0000_0100,
      NS_YELLOW = 9'b0_0000_1000,
      NS_CLEAR  = 9'b0_0001_0000,
      EW_GREEN  = 9'b0_0010_0000,
      EW_YELLOW = 9'b0_0100_0000,
      EW_CLEAR  = 9'b0_1000_0000,
      PED_WALK  = 9'b1_0000_0000
   } state_t;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   function automatic state_t green_of(input logic dir);
      return (dir == DIR_EW) ? EW_GREEN : NS_GREEN;
   endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase dwell counter: counts up from 0, holds on request, flags the last cycle of a phase.
module phase_timer #(
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          hold,
   input  logic [TW:0]   limit,
   output logic          done
);

   logic [TW-1:0] count;

   // limit is one bit wider than count so a phase of exactly 2^TW cycles is representable
   assign done = ({1'b0, count} == (limit - (TW+1)'(1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (!hold)
         count <= count + TW'(1);
   end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer with pedestrian walk phase and emergency pre-emption.
//  state     | meaning
//  OFF       | sequence disabled, all lamps dark
//  STARTUP   | initial all-red before first NS green
//  NS_GREEN  | NS green, EW red
//  NS_YELLOW | NS yellow, EW red
//  NS_CLEAR  | all-red clearance after NS
//  EW_GREEN  | EW green, NS red
//  EW_YELLOW | EW yellow, NS red
//  EW_CLEAR  | all-red clearance after EW
//  PED_WALK  | all-red with walk lamp lit
module intersection_ctrl
   import intersection_pkg::*;
#(
   parameter int T_GREEN  = 30,
   parameter int T_YELLOW = 10,
   parameter int T_ALLRED = 5,
   parameter int T_PED    = 20,
   parameter int TW       = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       ped_req,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [8:0] state_out
);

   localparam logic [TW:0] LIM_GREEN  = (TW+1)'(T_GREEN);
   localparam logic [TW:0] LIM_YELLOW = (TW+1)'(T_YELLOW);
   localparam logic [TW:0] LIM_ALLRED = (TW+1)'(T_ALLRED);
   localparam logic [TW:0] LIM_PED    = (TW+1)'(T_PED);

   state_t      state, state_next;
   logic        next_dir, next_dir_next;
   logic        ped_next;
   logic        timer_clear, timer_hold, timer_done;
   logic [TW:0] limit;

   phase_timer #(.TW(TW)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .hold    (timer_hold),
      .limit   (limit),
      .done    (timer_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= OFF;
         next_dir    <= DIR_NS;
         ped_pending <= 1'b0;
      end else begin
         state       <= state_next;
         next_dir    <= next_dir_next;
         ped_pending <= ped_next;
      end
   end

   always_comb begin
      state_next    = state;
      next_dir_next = next_dir;
      timer_hold    = 1'b0;
      limit         = (TW+1)'(1);
      case (state)
         OFF:       state_next = STARTUP;
         STARTUP: begin
            limit = LIM_ALLRED;
            if (timer_done) state_next = NS_GREEN;
         end
         NS_GREEN: begin
            limit = LIM_GREEN;
            if (emerg_req && emerg_dir == DIR_NS) timer_hold = 1'b1;
            else if (emerg_req || timer_done)     state_next = NS_YELLOW;
         end
         NS_YELLOW: begin
            limit = LIM_YELLOW;
            if (timer_done) state_next = NS_CLEAR;
         end
         NS_CLEAR: begin
            limit         = LIM_ALLRED;
            next_dir_next = DIR_EW;
            if (timer_done) begin
               if (emerg_req)        state_next = green_of(emerg_dir);
               else if (ped_pending) state_next = PED_WALK;
               else                  state_next = EW_GREEN;
            end
         end
         EW_GREEN: begin
            limit = LIM_GREEN;
            if (emerg_req && emerg_dir == DIR_EW) timer_hold = 1'b1;
            else if (emerg_req || timer_done)     state_next = EW_YELLOW;
         end
         EW_YELLOW: begin
            limit = LIM_YELLOW;
            if (timer_done) state_next = EW_CLEAR;
         end
         EW_CLEAR: begin
            limit         = LIM_ALLRED;
            next_dir_next = DIR_NS;
            if (timer_done) begin
               if (emerg_req)        state_next = green_of(emerg_dir);
               else if (ped_pending) state_next = PED_WALK;
               else                  state_next = NS_GREEN;
            end
         end
         PED_WALK: begin
            limit = LIM_PED;
            if (timer_done) state_next = green_of(next_dir);
         end
         default:   state_next = OFF;
      endcase

      if (!enable) state_next = OFF;

      timer_clear = !enable || (state == OFF) || (state_next != state);

      // entry into the walk phase serves the request, so a press on that edge is absorbed
      if (!enable)
         ped_next = 1'b0;
      else if (state_next == PED_WALK && state != PED_WALK)
         ped_next = 1'b0;
      else
         ped_next = ped_pending | ped_req;
   end

   always_comb begin
      ns_red    = 1'b0;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = 1'b0;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
      walk      = 1'b0;
      case (state)
         STARTUP, NS_CLEAR, EW_CLEAR: begin
            ns_red = 1'b1;
            ew_red = 1'b1;
         end
         PED_WALK: begin
            ns_red = 1'b1;
            ew_red = 1'b1;
            walk   = 1'b1;
         end
         NS_GREEN:  begin ns_green  = 1'b1; ew_red = 1'b1; end
         NS_YELLOW: begin ns_yellow = 1'b1; ew_red = 1'b1; end
         EW_GREEN:  begin ew_green  = 1'b1; ns_red = 1'b1; end
         EW_YELLOW: begin ew_yellow = 1'b1; ns_red = 1'b1; end
         default: ;
      endcase
   end

   assign state_out = state;

endmodule
